// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - shared types and constants for the inertial SPI interface
package inert_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        IDLE,
        RD_RTL,
        RD_RTH,
        RD_AZL,
        RD_AZH,
        UPD
    } inert_state_t;

    // IMU configuration writes, issued in this order after power-up settle
    localparam logic [15:0] CMD_INIT_INT  = 16'h0D02;
    localparam logic [15:0] CMD_INIT_AODR = 16'h1053;
    localparam logic [15:0] CMD_INIT_GODR = 16'h1150;
    localparam logic [15:0] CMD_INIT_RND  = 16'h1460;

    // Read addresses (bit 7 set marks a read)
    localparam logic [7:0] ADDR_RT_L = 8'hA2;
    localparam logic [7:0] ADDR_RT_H = 8'hA3;
    localparam logic [7:0] ADDR_AZ_L = 8'hAC;
    localparam logic [7:0] ADDR_AZ_H = 8'hAD;

    localparam logic [15:0] PTCH_RT_OFFSET = 16'h0050;
    localparam logic [15:0] AZ_OFFSET      = 16'h00A0;
    localparam int          FUSION_GAIN    = 1024;

    function automatic logic [15:0] rd_cmd(input logic [7:0] addr);
        return {addr, 8'h00};
    endfunction

endpackage

// File: rtl/inertial_integrator.sv
// rtl/inertial_integrator.sv - offset compensation, accel/gyro fusion and pitch integrator
module inertial_integrator
    import inert_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_i,
    input  logic [15:0] rate_raw_i,
    input  logic [15:0] az_raw_i,
    output logic [15:0] ptch_o,
    output logic [15:0] ptch_rt_o,
    output logic        vld_o
);

    localparam logic [26:0] GAIN_POS = 27'(FUSION_GAIN);
    localparam logic [26:0] GAIN_NEG = 27'(-FUSION_GAIN);

    logic [15:0] ptch_rt_comp;
    logic [15:0] az_comp;
    logic [25:0] prod;
    logic [15:0] ptch_acc;
    logic [26:0] fusion;
    logic [26:0] ptch_int_d;
    logic [26:0] ptch_int_q;
    logic [15:0] ptch_rt_q;
    logic        vld_q;

    // Low product bits fall below the accel-to-pitch scale and are dropped
    logic unused_prod;
    assign unused_prod = ^prod[12:0];

    // Next integrator value: subtract gyro rate, nudge toward accel-derived pitch
    always_comb begin
        ptch_rt_comp = rate_raw_i - PTCH_RT_OFFSET;
        az_comp      = az_raw_i - AZ_OFFSET;
        prod         = {{10{az_comp[15]}}, az_comp} * 26'd327;
        ptch_acc     = {{3{prod[25]}}, prod[25:13]};
        fusion       = ($signed(ptch_acc) > $signed(ptch_int_q[26:11])) ? GAIN_POS : GAIN_NEG;
        ptch_int_d   = ptch_int_q - {{11{ptch_rt_comp[15]}}, ptch_rt_comp} + fusion;
    end

    // Integrator and outputs advance together on the update cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_int_q <= '0;
            ptch_rt_q  <= '0;
            vld_q      <= 1'b0;
        end else begin
            vld_q <= upd_i;
            if (upd_i) begin
                ptch_int_q <= ptch_int_d;
                ptch_rt_q  <= ptch_rt_comp;
            end
        end
    end

    assign ptch_o    = ptch_int_q[26:11];
    assign ptch_rt_o = ptch_rt_q;
    assign vld_o     = vld_q;

endmodule

// File: rtl/inert_intf.sv
// rtl/inert_intf.sv - IMU SPI sequencer (INERT_FAST_SIM_EN shortens the power-up wait to 512 clks)
module inert_intf
    import inert_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    output logic        snd,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        vld,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt
);

`ifdef INERT_FAST_SIM_EN
    localparam int TMR_W = 9;
`else
    localparam int TMR_W = 16;
`endif

    inert_state_t      state_q;
    logic [TMR_W-1:0]  init_tmr_q;
    logic              snd_q;
    logic [15:0]       cmd_q;
    logic [7:0]        rt_l_q, rt_h_q, az_l_q, az_h_q;
    logic              int_s1_q, int_s2_q, int_s3_q;
    logic              int_rise;
    logic              done_ok;

    // Only the low byte of a read response carries register data
    logic unused_resp;
    assign unused_resp = ^resp[15:8];

    assign int_rise = int_s2_q & ~int_s3_q;
    // A done coinciding with our own request cannot be its answer
    assign done_ok  = done & ~snd_q;

    // Two flops to resolve metastability, third to detect the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1_q <= 1'b0;
            int_s2_q <= 1'b0;
            int_s3_q <= 1'b0;
        end else begin
            int_s1_q <= INT;
            int_s2_q <= int_s1_q;
            int_s3_q <= int_s2_q;
        end
    end

    // Sequencer: settle wait, config writes, then one 4-byte read set per INT edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_WAIT;
            init_tmr_q <= '0;
            snd_q      <= 1'b0;
            cmd_q      <= '0;
            rt_l_q     <= '0;
            rt_h_q     <= '0;
            az_l_q     <= '0;
            az_h_q     <= '0;
        end else begin
            snd_q <= 1'b0;
            unique case (state_q)
                INIT_WAIT: begin
                    init_tmr_q <= init_tmr_q + 1'b1;
                    if (&init_tmr_q) begin
                        state_q <= INIT1;
                        snd_q   <= 1'b1;
                        cmd_q   <= CMD_INIT_INT;
                    end
                end
                INIT1: if (done_ok) begin
                    state_q <= INIT2;
                    snd_q   <= 1'b1;
                    cmd_q   <= CMD_INIT_AODR;
                end
                INIT2: if (done_ok) begin
                    state_q <= INIT3;
                    snd_q   <= 1'b1;
                    cmd_q   <= CMD_INIT_GODR;
                end
                INIT3: if (done_ok) begin
                    state_q <= INIT4;
                    snd_q   <= 1'b1;
                    cmd_q   <= CMD_INIT_RND;
                end
                INIT4: if (done_ok) begin
                    state_q <= IDLE;
                end
                IDLE: if (int_rise) begin
                    state_q <= RD_RTL;
                    snd_q   <= 1'b1;
                    cmd_q   <= rd_cmd(ADDR_RT_L);
                end
                RD_RTL: if (done_ok) begin
                    rt_l_q  <= resp[7:0];
                    state_q <= RD_RTH;
                    snd_q   <= 1'b1;
                    cmd_q   <= rd_cmd(ADDR_RT_H);
                end
                RD_RTH: if (done_ok) begin
                    rt_h_q  <= resp[7:0];
                    state_q <= RD_AZL;
                    snd_q   <= 1'b1;
                    cmd_q   <= rd_cmd(ADDR_AZ_L);
                end
                RD_AZL: if (done_ok) begin
                    az_l_q  <= resp[7:0];
                    state_q <= RD_AZH;
                    snd_q   <= 1'b1;
                    cmd_q   <= rd_cmd(ADDR_AZ_H);
                end
                RD_AZH: if (done_ok) begin
                    az_h_q  <= resp[7:0];
                    state_q <= UPD;
                end
                UPD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= INIT_WAIT;
                end
            endcase
        end
    end

    inertial_integrator u_integrator (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_i      (state_q == UPD),
        .rate_raw_i ({rt_h_q, rt_l_q}),
        .az_raw_i   ({az_h_q, az_l_q}),
        .ptch_o     (ptch),
        .ptch_rt_o  (ptch_rt),
        .vld_o      (vld)
    );

    assign snd = snd_q;
    assign cmd = cmd_q;

endmodule

// File: tb/tb_inert_intf.sv
// tb/tb_inert_intf.sv - scoreboard bench for inert_intf with an SPI slave model
module tb_inert_intf;

`ifdef INERT_FAST_SIM_EN
    localparam int TMR_W = 9;
`else
    localparam int TMR_W = 16;
`endif

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;
    logic        vld;
    logic [15:0] ptch;
    logic [15:0] ptch_rt;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cyc = 0;
    int vld_cnt = 0;
    int snd_cnt = 0;
    int first_snd_cyc = -1;
    int spi_lat = 4;
    int pi = 0;
    logic [7:0]  last_addr = 8'h00;
    logic [15:0] cur_rate = 16'h0000;
    logic [15:0] cur_az = 16'h0000;
    logic [15:0] exp_cmd_q[$];
    logic [31:0] exp_out_q[$];

    typedef struct {
        logic [15:0] rate;
        logic [15:0] az;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[4];

    inert_intf dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .snd     (snd),
        .cmd     (cmd),
        .done    (done),
        .resp    (resp),
        .vld     (vld),
        .ptch    (ptch),
        .ptch_rt (ptch_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_reads();
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        exp_cmd_q.push_back(16'hAD00);
    endtask

    task automatic push_init();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1053);
        exp_cmd_q.push_back(16'h1150);
        exp_cmd_q.push_back(16'h1460);
    endtask

    // Reference pitch model kept as a 32-bit int wrapped to 27 bits
    task automatic model_step(input logic [15:0] rate, input logic [15:0] az, output logic [31:0] res);
        logic [15:0] rtc;
        logic [15:0] azc;
        int rt, azi, acc, cur;
        rtc = rate - 16'h0050;
        azc = az - 16'h00A0;
        rt  = int'($signed(rtc));
        azi = int'($signed(azc));
        acc = (azi * 327) >>> 13;
        cur = pi >>> 11;
        pi  = pi - rt + ((acc > cur) ? 1024 : -1024);
        pi  = (pi <<< 5) >>> 5;
        res = {rtc, 16'(pi >>> 11)};
    endtask

    task automatic wait_vld(input int v0, input string name);
        int i;
        for (i = 0; i < 3000 && vld_cnt == v0; i++) @(negedge clk);
        if (vld_cnt == v0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no vld within %0d cycles", name, i);
        end
    endtask

    task automatic sample(input logic [15:0] rate, input logic [15:0] az, input logic use_hand,
                          input logic [31:0] hand, input int hold);
        logic [31:0] m;
        int v0;
        repeat (3) @(negedge clk);
        cur_rate = rate;
        cur_az   = az;
        push_reads();
        model_step(rate, az, m);
        exp_out_q.push_back(use_hand ? hand : m);
        v0 = vld_cnt;
        INT = 1'b1;
        repeat (hold) @(negedge clk);
        INT = 1'b0;
        wait_vld(v0, "sample_vld");
    endtask

    // SPI slave: checks each request against the expected command stream, answers after spi_lat clks
    initial begin
        int lat;
        logic busy;
        logic [15:0] hold;
        busy = 1'b0;
        lat  = 0;
        hold = '0;
        done = 1'b0;
        resp = '0;
        forever begin
            @(posedge clk);
            #1;
            done = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (busy) begin
                if (snd) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL snd_while_busy: got snd=1 expected 0 (cmd %h)", cmd);
                end
                if (lat == 0) begin
                    check("cmd_hold", 32'(cmd), 32'(hold));
                    done = 1'b1;
                    case (hold[15:8])
                        8'hA2:   resp = {8'h5A, cur_rate[7:0]};
                        8'hA3:   resp = {8'h5A, cur_rate[15:8]};
                        8'hAC:   resp = {8'h5A, cur_az[7:0]};
                        8'hAD:   resp = {8'h5A, cur_az[15:8]};
                        default: resp = 16'h5AEE;
                    endcase
                    if (hold[15:8] == 8'hAD) done_cyc = cyc;
                    busy = 1'b0;
                end else begin
                    lat--;
                end
            end else if (snd) begin
                snd_cnt++;
                if (first_snd_cyc < 0) first_snd_cyc = cyc;
                if (exp_cmd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_snd: got cmd %h expected no request", cmd);
                end else begin
                    check("cmd_seq", 32'(cmd), 32'(exp_cmd_q.pop_front()));
                end
                hold      = cmd;
                last_addr = cmd[15:8];
                busy      = 1'b1;
                lat       = spi_lat - 1;
            end
        end
    end

    // Output monitor: pops the scoreboard on every vld pulse
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && vld) begin
                vld_cnt++;
                if (exp_out_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_vld: got ptch=%h ptch_rt=%h expected no vld", ptch, ptch_rt);
                end else begin
                    e = exp_out_q.pop_front();
                    check("ptch_rt", 32'(ptch_rt), 32'(e[31:16]));
                    check("ptch", 32'(ptch), 32'(e[15:0]));
                end
                check("vld_latency", 32'(cyc - done_cyc), 32'd2);
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc, v0, s0, i;
        logic [31:0] m;

        vecs[0] = '{16'h0050, 16'h00A0, 32'h0000_FFFF};
        vecs[1] = '{16'h0050, 16'h40A0, 32'h0000_0000};
        vecs[2] = '{16'h0450, 16'h00A0, 32'h0400_FFFF};
        vecs[3] = '{16'h0040, 16'hC0A0, 32'hFFF0_FFFE};

        rst_n = 1'b0;
        INT   = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_snd", 32'(snd), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_ptch", 32'(ptch), 32'd0);
        check("rst_ptch_rt", 32'(ptch_rt), 32'd0);

        // Power-up wait and the four configuration writes
        push_init();
        rel_cyc = cyc;
        rst_n   = 1'b1;
        for (i = 0; i < (1 << TMR_W) + 2000 && snd_cnt < 4; i++) @(negedge clk);
        repeat (spi_lat + 10) @(negedge clk);
        check("init_cmds_left", 32'(exp_cmd_q.size()), 32'd0);
        check("init_snd_count", 32'(snd_cnt), 32'd4);
        check("init_first_snd", 32'(first_snd_cyc - rel_cyc), 32'(1 << TMR_W));
        check("init_no_vld", 32'(vld_cnt), 32'd0);

        // Hand-computed vectors
        foreach (vecs[k]) sample(vecs[k].rate, vecs[k].az, 1'b1, vecs[k].exp, 3);

        // Long run with constant rate bias, model-tracked
        spi_lat = 2;
        for (int k = 0; k < 128; k++) sample(16'h0150, 16'h00A0, 1'b0, 32'd0, 3);
        check("bias_ptch_rt", 32'(ptch_rt), 32'h0100);

        // Level-high INT must not retrigger
        spi_lat = 4;
        v0 = vld_cnt;
        sample(16'h0150, 16'h00A0, 1'b0, 32'd0, 3000);
        check("level_one_vld", 32'(vld_cnt - v0), 32'd1);
        sample(16'h0150, 16'h00A0, 1'b0, 32'd0, 3);
        check("level_second_vld", 32'(vld_cnt - v0), 32'd2);

        // INT edge during RD_RTH is discarded
        spi_lat   = 8;
        last_addr = 8'h00;
        repeat (3) @(negedge clk);
        cur_rate = 16'h0250;
        cur_az   = 16'h10A0;
        push_reads();
        model_step(cur_rate, cur_az, m);
        exp_out_q.push_back(m);
        v0  = vld_cnt;
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        for (i = 0; i < 500 && last_addr != 8'hA3; i++) @(negedge clk);
        check("mid_read_reach_rth", 32'(last_addr), 32'hA3);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_vld(v0, "mid_read_vld");
        repeat (150) @(negedge clk);
        check("mid_read_one_vld", 32'(vld_cnt - v0), 32'd1);
        check("mid_read_no_extra_cmds", 32'(exp_cmd_q.size()), 32'd0);

        // Reset during RD_AZL clears everything and replays init
        spi_lat   = 4;
        last_addr = 8'h00;
        cur_rate  = 16'h0350;
        cur_az    = 16'h20A0;
        push_reads();
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        for (i = 0; i < 500 && last_addr != 8'hAC; i++) @(negedge clk);
        check("rst_mid_reach_azl", 32'(last_addr), 32'hAC);
        rst_n = 1'b0;
        #1;
        check("rst_mid_snd", 32'(snd), 32'd0);
        check("rst_mid_cmd", 32'(cmd), 32'd0);
        check("rst_mid_vld", 32'(vld), 32'd0);
        check("rst_mid_ptch", 32'(ptch), 32'd0);
        check("rst_mid_ptch_rt", 32'(ptch_rt), 32'd0);
        exp_cmd_q.delete();
        exp_out_q.delete();
        pi = 0;
        repeat (3) @(negedge clk);
        push_init();
        s0    = snd_cnt;
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("replay_wait_no_snd", 32'(snd_cnt - s0), 32'd0);
`ifndef INERT_FAST_SIM_EN
        force dut.init_tmr_q = 16'hFF00;
        @(negedge clk);
        release dut.init_tmr_q;
`endif
        for (i = 0; i < (1 << TMR_W) + 2000 && (snd_cnt - s0) < 4; i++) @(negedge clk);
        repeat (spi_lat + 10) @(negedge clk);
        check("replay_cmds_left", 32'(exp_cmd_q.size()), 32'd0);
        check("replay_snd_count", 32'(snd_cnt - s0), 32'd4);
        sample(vecs[0].rate, vecs[0].az, 1'b1, vecs[0].exp, 3);
        repeat (20) @(negedge clk);
        check("final_out_queue", 32'(exp_out_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
